// File: rtl/lap_stop_watch_pkg.sv
// Shared types for the lap stop watch: FSM state, default lap entry and default limits.
package stop_watch_pkg;
  localparam int SW_CNT_W   = 6;
  localparam int SW_SEC_MAX = 59;
  localparam int SW_MIN_MAX = 59;

  typedef enum logic [1:0] {IDLE, RUN, STOP, RECALL} sw_state_e;

  typedef struct packed {
    logic [SW_CNT_W-1:0] min;
    logic [SW_CNT_W-1:0] sec;
  } lap_t;
endpackage

// File: rtl/lap_stop_watch_if.sv
// Button/display bundle between the mode controller (master) and the lap stop watch (slave).
interface lap_stop_watch_if #(
  parameter int CNT_W     = 6,
  parameter int LAP_DEPTH = 4
);
  localparam int IW = $clog2(LAP_DEPTH);

  logic             stop_watch_en;
  logic             start_stop_button;
  logic             lap_button;
  logic             clear_button;
  logic [CNT_W-1:0] o_minutes;
  logic [CNT_W-1:0] o_seconds;
  logic [IW:0]      lap_count;
  logic [IW-1:0]    lap_index;
  logic             recall_active;
  logic             overflow_flag;
  logic             stop_watch_ack_flag;

  modport master (
    output stop_watch_en, start_stop_button, lap_button, clear_button,
    input  o_minutes, o_seconds, lap_count, lap_index, recall_active,
           overflow_flag, stop_watch_ack_flag
  );

  modport slave (
    input  stop_watch_en, start_stop_button, lap_button, clear_button,
    output o_minutes, o_seconds, lap_count, lap_index, recall_active,
           overflow_flag, stop_watch_ack_flag
  );
endinterface

// File: rtl/lap_stop_watch_lap_buffer.sv
// Circular lap store; read port addresses entries by age, offset 0 = newest capture.
module lap_buffer
  import stop_watch_pkg::*;
#(
  parameter int  LAP_DEPTH = 4,
  parameter type T         = lap_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_we,
  input  T                             i_wdata,
  input  logic [$clog2(LAP_DEPTH)-1:0] i_rd_off,
  output T                             o_rdata,
  output logic [$clog2(LAP_DEPTH):0]   o_lap_count
);
  localparam int IW = $clog2(LAP_DEPTH);
  localparam int LW = IW + 1;

  T              r_mem [LAP_DEPTH];
  logic [IW-1:0] r_wr_ptr;
  logic [IW:0]   r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_we) begin
      r_mem[r_wr_ptr] <= i_wdata;
      r_wr_ptr        <= r_wr_ptr + IW'(1);
      if (r_cnt != LW'(LAP_DEPTH)) r_cnt <= r_cnt + LW'(1);
    end
  end

  // Power-of-two depth lets the pointer subtraction wrap for free.
  assign o_rdata     = r_mem[r_wr_ptr - IW'(1) - i_rd_off];
  assign o_lap_count = r_cnt;
endmodule

// File: rtl/lap_stop_watch.sv
// MM:SS stop watch with prescaled tick, circular lap store and lap browsing while stopped.
// Optional macro STOP_WATCH_SPLIT_HOLD_EN: a lap in RUN freezes the display on the captured time.
module lap_stop_watch
  import stop_watch_pkg::*;
#(
  parameter int CNT_W     = SW_CNT_W,
  parameter int SEC_MAX   = SW_SEC_MAX,
  parameter int MIN_MAX   = SW_MIN_MAX,
  parameter int LAP_DEPTH = 4,
  parameter int TICK_DIV  = 1
) (
  input logic             clk,
  input logic             rst,
  lap_stop_watch_if.slave bus
);
  localparam int IW = $clog2(LAP_DEPTH);
  localparam int LW = IW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef struct packed {
    logic [CNT_W-1:0] min;
    logic [CNT_W-1:0] sec;
  } entry_t;

  sw_state_e     r_state;
  logic [CNT_W-1:0] r_min, r_sec, r_disp_min, r_disp_sec;
  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_idx;
  logic          r_ovf, r_ack, r_recall;
`ifdef STOP_WATCH_SPLIT_HOLD_EN
  logic          r_hold;
  entry_t        r_hold_val;
`endif

  logic          w_en, w_tick, w_acc_clr, w_acc_ss, w_acc_lap, w_cap, w_lap_ok;
  logic [IW:0]   w_lap_count;
  entry_t        w_rd, w_live;

  assign w_en   = bus.stop_watch_en;
  assign w_tick = (r_state == RUN) && (r_presc == PW'(TICK_DIV - 1));
  assign w_live = '{min: r_min, sec: r_sec};

  // Priority is applied among commands the current state would honour.
  assign w_lap_ok  = (r_state == RUN) || (r_state == RECALL) ||
                     ((r_state == STOP) && (w_lap_count != '0));
  assign w_acc_clr = w_en && bus.clear_button && ((r_state == STOP) || (r_state == RECALL));
  assign w_acc_ss  = w_en && bus.start_stop_button && !w_acc_clr;
  assign w_acc_lap = w_en && bus.lap_button && !w_acc_clr && !w_acc_ss && w_lap_ok;
  assign w_cap     = w_acc_lap && (r_state == RUN);

  lap_buffer #(.LAP_DEPTH(LAP_DEPTH), .T(entry_t)) u_lap_buffer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_acc_clr),
    .i_we       (w_cap),
    .i_wdata    (w_live),
    .i_rd_off   (r_idx),
    .o_rdata    (w_rd),
    .o_lap_count(w_lap_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_min      <= '0;
      r_sec      <= '0;
      r_presc    <= '0;
      r_idx      <= '0;
      r_ovf      <= 1'b0;
      r_ack      <= 1'b0;
      r_recall   <= 1'b0;
      r_disp_min <= '0;
      r_disp_sec <= '0;
`ifdef STOP_WATCH_SPLIT_HOLD_EN
      r_hold     <= 1'b0;
      r_hold_val <= '0;
`endif
    end else begin
      r_ack <= w_acc_clr || w_acc_ss || w_acc_lap;

      if (w_acc_clr) begin
        r_min   <= '0;
        r_sec   <= '0;
        r_presc <= '0;
        r_ovf   <= 1'b0;
      end else if (r_state == RUN) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          if (r_sec == CNT_W'(SEC_MAX)) begin
            r_sec <= '0;
            if (r_min == CNT_W'(MIN_MAX)) begin
              r_min <= '0;
              r_ovf <= 1'b1;
            end else begin
              r_min <= r_min + CNT_W'(1);
            end
          end else begin
            r_sec <= r_sec + CNT_W'(1);
          end
        end
      end

      case (r_state)
        IDLE:   if (w_acc_ss) r_state <= RUN;
        RUN:    if (w_acc_ss) r_state <= STOP;
        STOP: begin
          if (w_acc_clr)     r_state <= IDLE;
          else if (w_acc_ss) r_state <= RUN;
          else if (w_acc_lap) begin
            r_state <= RECALL;
            r_idx   <= '0;
          end
        end
        RECALL: begin
          if (!w_en)          r_state <= STOP;
          else if (w_acc_clr) r_state <= IDLE;
          else if (w_acc_ss)  r_state <= STOP;
          else if (w_acc_lap)
            r_idx <= ({1'b0, r_idx} == w_lap_count - LW'(1)) ? '0 : r_idx + IW'(1);
        end
        default: r_state <= IDLE;
      endcase

`ifdef STOP_WATCH_SPLIT_HOLD_EN
      if (w_acc_clr || (w_acc_ss && r_state == RUN)) begin
        r_hold <= 1'b0;
      end else if (w_cap) begin
        r_hold     <= 1'b1;
        r_hold_val <= w_live;
      end
`endif

      r_recall <= (r_state == RECALL);
      if (r_state == RECALL) begin
        r_disp_min <= w_rd.min;
        r_disp_sec <= w_rd.sec;
`ifdef STOP_WATCH_SPLIT_HOLD_EN
      end else if (r_hold) begin
        r_disp_min <= r_hold_val.min;
        r_disp_sec <= r_hold_val.sec;
`endif
      end else begin
        r_disp_min <= r_min;
        r_disp_sec <= r_sec;
      end
    end
  end

  assign bus.o_minutes           = r_disp_min;
  assign bus.o_seconds           = r_disp_sec;
  assign bus.lap_count           = w_lap_count;
  assign bus.lap_index           = r_idx;
  assign bus.recall_active       = r_recall;
  assign bus.overflow_flag       = r_ovf;
  assign bus.stop_watch_ack_flag = r_ack;
endmodule

// File: tb/tb_lap_stop_watch.sv
// Bench for lap_stop_watch: directed plan plus random buttons against an elapsed-seconds model.
module tb_lap_stop_watch;
  localparam int CNT_W = 6, SEC_MAX = 59, MIN_MAX = 59, LAP_DEPTH = 4;
  localparam int MODN  = (SEC_MAX + 1) * (MIN_MAX + 1);
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_RECALL = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lap_stop_watch_if #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH)) bus1 ();
  lap_stop_watch_if #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH)) bus4 ();

  lap_stop_watch #(.CNT_W(CNT_W), .SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX),
                   .LAP_DEPTH(LAP_DEPTH), .TICK_DIV(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  lap_stop_watch #(.CNT_W(CNT_W), .SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX),
                   .LAP_DEPTH(LAP_DEPTH), .TICK_DIV(4))
    dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: elapsed whole seconds, cycles since last tick, laps newest-first.
  int m_mode = M_IDLE, m_t = 0, m_ps = 0, m_idx = 0;
  bit m_ovf = 1'b0, m_hold = 1'b0;
  int m_hold_t = 0;
  int m_laps[$];
  int e_disp = 0;
  bit e_rec = 1'b0, e_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("%s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit en, input bit ss, input bit lp, input bit cl);
    bit ac, as, al, tick;
    int nl;
    bus1.stop_watch_en = en; bus1.start_stop_button = ss;
    bus1.lap_button = lp;    bus1.clear_button = cl;
    nl = m_laps.size();
    if (m_mode == M_RECALL) e_disp = m_laps[m_idx];
    else if (m_hold)        e_disp = m_hold_t;
    else                    e_disp = m_t;
    e_rec = (m_mode == M_RECALL);
    ac = en && cl && (m_mode == M_STOP || m_mode == M_RECALL);
    as = en && ss && !ac;
    al = en && lp && !ac && !as &&
         (m_mode == M_RUN || m_mode == M_RECALL || (m_mode == M_STOP && nl > 0));
    e_ack = ac || as || al;
    tick = (m_mode == M_RUN) && (m_ps + 1 == 1);
    if (al && m_mode == M_RUN) begin
      m_laps.push_front(m_t);
      if (m_laps.size() > LAP_DEPTH) void'(m_laps.pop_back());
`ifdef STOP_WATCH_SPLIT_HOLD_EN
      m_hold = 1'b1; m_hold_t = m_t;
`endif
    end
    if (ac || (as && m_mode == M_RUN)) m_hold = 1'b0;
    if (ac) begin
      m_t = 0; m_ps = 0; m_ovf = 1'b0; m_laps.delete();
    end else if (m_mode == M_RUN) begin
      if (tick) begin
        m_ps = 0;
        m_t  = (m_t + 1) % MODN;
        if (m_t == 0) m_ovf = 1'b1;
      end else m_ps++;
    end
    case (m_mode)
      M_IDLE: if (as) m_mode = M_RUN;
      M_RUN:  if (as) m_mode = M_STOP;
      M_STOP: if (ac) m_mode = M_IDLE; else if (as) m_mode = M_RUN;
              else if (al) begin m_mode = M_RECALL; m_idx = 0; end
      default: if (!en) m_mode = M_STOP; else if (ac) m_mode = M_IDLE;
               else if (as) m_mode = M_STOP; else if (al) m_idx = (m_idx + 1) % nl;
    endcase
    @(posedge clk); #1;
    chk("minutes",   32'(bus1.o_minutes), e_disp / (SEC_MAX + 1));
    chk("seconds",   32'(bus1.o_seconds), e_disp % (SEC_MAX + 1));
    chk("lap_count", 32'(bus1.lap_count), m_laps.size());
    chk("lap_index", 32'(bus1.lap_index), m_idx);
    chk("recall",    32'(bus1.recall_active), int'(e_rec));
    chk("overflow",  32'(bus1.overflow_flag), int'(m_ovf));
    chk("ack",       32'(bus1.stop_watch_ack_flag), int'(e_ack));
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 4000 && m_t != target; i++) step(1, 0, 0, 0);
    chk("run_to", 32'(m_t), target);
  endtask

  task automatic step4(input bit ss);
    bus4.stop_watch_en = 1'b1; bus4.start_stop_button = ss;
    @(posedge clk); #1;
  endtask

  int exp_l[5] = '{15, 12, 10, 7, 15};

  initial begin
    bus1.stop_watch_en = 0; bus1.start_stop_button = 0; bus1.lap_button = 0; bus1.clear_button = 0;
    bus4.stop_watch_en = 0; bus4.start_stop_button = 0; bus4.lap_button = 0; bus4.clear_button = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_min",   32'(bus1.o_minutes), 0);
    chk("rst_sec",   32'(bus1.o_seconds), 0);
    chk("rst_laps",  32'(bus1.lap_count), 0);
    chk("rst_ovf",   32'(bus1.overflow_flag), 0);
    chk("rst_ack",   32'(bus1.stop_watch_ack_flag), 0);
    chk("rst4_sec",  32'(bus4.o_seconds), 0);
    rst = 1'b1;

    // 125 ticks then stop
    step(1, 1, 0, 0);
    chk("ack_start", 32'(bus1.stop_watch_ack_flag), 1);
    repeat (124) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("ack_stop", 32'(bus1.stop_watch_ack_flag), 1);
    step(1, 0, 0, 0);
    chk("t125_min", 32'(bus1.o_minutes), 2);
    chk("t125_sec", 32'(bus1.o_seconds), 5);

    // full wrap to 00:00 sets overflow; clear drops it
    step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    repeat (3599) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("ovf_set", 32'(bus1.overflow_flag), 1);
    step(1, 0, 0, 0);
    chk("wrap_min", 32'(bus1.o_minutes), 0);
    chk("wrap_sec", 32'(bus1.o_seconds), 0);
    step(1, 0, 0, 1);
    chk("ovf_clr", 32'(bus1.overflow_flag), 0);
    step(1, 0, 0, 0);
    chk("clr_sec", 32'(bus1.o_seconds), 0);

    // five laps into a four-deep buffer, then browse
    step(1, 1, 0, 0);
    run_to(3);  step(1, 0, 1, 0);
    run_to(7);  step(1, 0, 1, 0);
    run_to(10); step(1, 0, 1, 0);
    run_to(12); step(1, 0, 1, 0);
    run_to(15); step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 0);
      step(1, 0, 0, 0);
      chk("recall_sec", 32'(bus1.o_seconds), exp_l[i]);
    end
    chk("laps_full", 32'(bus1.lap_count), 4);

    // clear beats start_stop and lap; clear in RUN ignored
    step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    chk("prio_ack", 32'(bus1.stop_watch_ack_flag), 1);
    step(1, 0, 0, 0);
    chk("prio_ack_once", 32'(bus1.stop_watch_ack_flag), 0);
    chk("prio_laps", 32'(bus1.lap_count), 0);
    step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("run_clr_ack", 32'(bus1.stop_watch_ack_flag), 0);
    step(1, 0, 0, 0);

    // random buttons and enable
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);

`ifdef STOP_WATCH_SPLIT_HOLD_EN
    if (m_mode == M_RECALL) step(1, 1, 0, 0);
    if (m_mode == M_RUN)    step(1, 1, 0, 0);
    if (m_mode == M_STOP)   step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    run_to(4);
    step(1, 0, 1, 0);
    repeat (5) step(1, 0, 0, 0);
    chk("hold_sec", 32'(bus1.o_seconds), 4);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
`endif

    // TICK_DIV=4: prescaler holds across stops
    step4(1);
    repeat (19) step4(0);
    step4(1); step4(0);
    chk("div4_min", 32'(bus4.o_minutes), 0);
    chk("div4_sec5", 32'(bus4.o_seconds), 5);
    repeat (9) step4(0);
    step4(1);
    repeat (3) step4(0);
    step4(1); step4(0);
    chk("div4_sec6", 32'(bus4.o_seconds), 6);
    step4(1); step4(0); step4(1);
    repeat (5) step4(0);
    step4(1); step4(0); step4(1); step4(0);
    chk("div4_sec7", 32'(bus4.o_seconds), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
